// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB-lite master-port arbiter.
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } arb_state_t;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0]  HSIZE_BYTE = 3'b000;
   localparam logic [2:0]  HSIZE_HALF = 3'b001;
   localparam logic [2:0]  HSIZE_WORD = 3'b010;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ahb_master_arb_if.sv
// Requester command bus plus AHB-lite master pins; the arbiter uses the master modport.
interface ahb_master_arb_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0][31:0] req_addr;
   logic [NREQ-1:0][31:0] req_wdata;
   logic [NREQ-1:0]       req_write;
   logic [NREQ-1:0][2:0]  req_size;
   logic [NREQ-1:0]       ack;
   logic [31:0]           rdata;
   logic                  err;
   logic [1:0]            gnt_id;
   logic                  busy;

   logic [31:0]           M_HADDR;
   logic [31:0]           M_HWDATA;
   logic                  M_HWRITE;
   logic [1:0]            M_HTRANS;
   logic [2:0]            M_HSIZE;
   logic [31:0]           M_HRDATA;
   logic                  M_HREADY;
   logic                  M_HRESP;

   modport master (
      input  req, req_addr, req_wdata, req_write, req_size,
      output ack, rdata, err, gnt_id, busy,
      output M_HADDR, M_HWDATA, M_HWRITE, M_HTRANS, M_HSIZE,
      input  M_HRDATA, M_HREADY, M_HRESP
   );

   modport slave (
      output req, req_addr, req_wdata, req_write, req_size,
      input  ack, rdata, err, gnt_id, busy,
      input  M_HADDR, M_HWDATA, M_HWRITE, M_HTRANS, M_HSIZE,
      output M_HRDATA, M_HREADY, M_HRESP
   );
endinterface

// File: rtl/ahb_master_arb_rr_pick.sv
// Combinational round-robin selector: the first requester after last_gnt (mod NREQ) wins.
module rr_pick #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last_gnt,
   output logic [1:0]      winner,
   output logic            valid
);

   logic hit_s;

   // Scan farthest to nearest so the nearest requesting index is the final write
   always_comb begin
      winner = 2'd0;
      valid  = 1'b0;
      hit_s  = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         for (int j = 0; j < NREQ; j++) begin
            hit_s  = req[j] && (j == ((int'(last_gnt) + k) % NREQ));
            winner = hit_s ? 2'(j) : winner;
            valid  = valid | hit_s;
         end
      end
   end

endmodule

// File: rtl/ahb_master_arb.sv
// Round-robin arbiter sequencing one single-beat AHB-lite NONSEQ transfer per grant.
// Optional data-phase watchdog enabled by defining AHB_ARB_TIMEOUT_EN.
module ahb_master_arb
   import ahb_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rstn,
   ahb_master_arb_if.master bus
);

   arb_state_t      state_r;
   logic [1:0]      last_gnt_r;
   logic [1:0]      pick_id_s;
   logic            pick_valid_s;
   logic [31:0]     sel_addr_s;
   logic [31:0]     sel_wdata_s;
   logic            sel_write_s;
   logic [2:0]      sel_size_s;
   logic [NREQ-1:0] gnt_onehot_s;

`ifdef AHB_ARB_TIMEOUT_EN
   logic [15:0]     wait_cnt_r;
`else
   logic [15:0]     timeout_unused_s;
   assign timeout_unused_s = 16'(TIMEOUT);
`endif

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req      (bus.req),
      .last_gnt (last_gnt_r),
      .winner   (pick_id_s),
      .valid    (pick_valid_s)
   );

   // Steer the winner's command and decode the current grant as a one-hot ack vector
   always_comb begin
      sel_addr_s   = 32'h0;
      sel_wdata_s  = 32'h0;
      sel_write_s  = 1'b0;
      sel_size_s   = HSIZE_WORD;
      gnt_onehot_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         sel_addr_s      = (pick_id_s == 2'(k)) ? bus.req_addr[k]  : sel_addr_s;
         sel_wdata_s     = (pick_id_s == 2'(k)) ? bus.req_wdata[k] : sel_wdata_s;
         sel_write_s     = (pick_id_s == 2'(k)) ? bus.req_write[k] : sel_write_s;
         sel_size_s      = (pick_id_s == 2'(k)) ? bus.req_size[k]  : sel_size_s;
         gnt_onehot_s[k] = (bus.gnt_id == 2'(k));
      end
   end

   // Transfer sequencer; every requester-side and bus-side output is a flop
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= ST_IDLE;
         last_gnt_r   <= 2'(NREQ - 1);
         bus.gnt_id   <= 2'd0;
         bus.ack      <= '0;
         bus.err      <= 1'b0;
         bus.rdata    <= 32'h0;
         bus.busy     <= 1'b0;
         bus.M_HTRANS <= HTRANS_IDLE;
         bus.M_HADDR  <= 32'h0;
         bus.M_HWDATA <= 32'h0;
         bus.M_HWRITE <= 1'b0;
         bus.M_HSIZE  <= HSIZE_WORD;
`ifdef AHB_ARB_TIMEOUT_EN
         wait_cnt_r   <= 16'd0;
`endif
      end else begin
         bus.ack <= '0;
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  bus.gnt_id   <= pick_id_s;
                  bus.M_HADDR  <= sel_addr_s;
                  bus.M_HWDATA <= sel_wdata_s;
                  bus.M_HWRITE <= sel_write_s;
                  bus.M_HSIZE  <= sel_size_s;
                  bus.M_HTRANS <= HTRANS_NONSEQ;
                  bus.busy     <= 1'b1;
                  state_r      <= ST_ADDR;
               end else begin
                  state_r      <= ST_IDLE;
               end
            end
            ST_ADDR: begin
               if (bus.M_HREADY) begin
                  bus.M_HTRANS <= HTRANS_IDLE;
                  state_r      <= ST_DATA;
`ifdef AHB_ARB_TIMEOUT_EN
                  wait_cnt_r   <= 16'd0;
`endif
               end else begin
                  state_r      <= ST_ADDR;
               end
            end
            ST_DATA: begin
               if (bus.M_HREADY) begin
                  if (!bus.M_HWRITE) begin
                     bus.rdata <= bus.M_HRDATA;
                  end else begin
                     bus.rdata <= bus.rdata;
                  end
                  bus.err <= bus.M_HRESP;
                  bus.ack <= gnt_onehot_s;
                  state_r <= ST_DONE;
               end
`ifdef AHB_ARB_TIMEOUT_EN
               else if (wait_cnt_r == 16'(TIMEOUT - 1)) begin
                  bus.err   <= 1'b1;
                  bus.rdata <= TIMEOUT_DATA;
                  bus.ack   <= gnt_onehot_s;
                  state_r   <= ST_DONE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
`else
               else begin
                  state_r <= ST_DATA;
               end
`endif
            end
            ST_DONE: begin
               last_gnt_r <= bus.gnt_id;
               bus.busy   <= 1'b0;
               state_r    <= ST_IDLE;
            end
            default: begin
               bus.busy     <= 1'b0;
               bus.M_HTRANS <= HTRANS_IDLE;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master_arb.sv
// Self-checking bench for ahb_master_arb: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_ahb_master_arb;
   import ahb_arb_pkg::*;

   localparam int NREQ = 2;
`ifdef AHB_ARB_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1024;
`endif

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   ahb_master_arb_if #(.NREQ(NREQ)) bus ();

   ahb_master_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks = 0;
   int failures = 0;

   // Transaction-level model state
   int          last_gnt_m;
   logic [31:0] rdata_m;
   logic [31:0] cmd_addr  [NREQ];
   logic [31:0] cmd_wdata [NREQ];
   logic        cmd_write [NREQ];
   logic [2:0]  cmd_size  [NREQ];

   function automatic int pick(input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (last_gnt_m + k) % NREQ;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_cmd(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic wr, input logic [2:0] sz);
      cmd_addr[i] = a;  cmd_wdata[i] = d;  cmd_write[i] = wr;  cmd_size[i] = sz;
      bus.req_addr[i] = a;  bus.req_wdata[i] = d;  bus.req_write[i] = wr;  bus.req_size[i] = sz;
   endtask

   // Runs one transfer from an IDLE negedge with requests already raised; returns the winner.
   task automatic xfer(input int aw, input int dw, input bit eresp, input logic [31:0] hrd,
                       input bit keep, input bit drop_early, output int won);
      int w;
      int len;
      logic [31:0]     exp_rd;
      logic [NREQ-1:0] exp_ack;
      w = pick(bus.req);
      won = w;
      checks++;
      if (w < 0) begin
         failures++;
         $display("FAIL xfer_setup: no requester raised, req=%b", bus.req);
         return;
      end
      len = 3 + aw + dw;
      exp_rd = cmd_write[w] ? rdata_m : hrd;
      exp_ack = '0;
      exp_ack[w] = 1'b1;
      for (int c = 1; c <= len + 1; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c <= 1 + aw) begin
            checks++;
            if (bus.M_HTRANS !== HTRANS_NONSEQ || bus.M_HADDR !== cmd_addr[w] ||
                bus.M_HWRITE !== cmd_write[w] || bus.M_HSIZE !== cmd_size[w] ||
                bus.gnt_id !== 2'(w) || bus.busy !== 1'b1 || bus.ack !== '0) begin
               failures++;
               $display("FAIL addr_phase c=%0d: trans=%b addr=%h wr=%b size=%0d gnt=%0d busy=%b ack=%b want trans=10 addr=%h wr=%b size=%0d gnt=%0d busy=1 ack=0",
                        c, bus.M_HTRANS, bus.M_HADDR, bus.M_HWRITE, bus.M_HSIZE, bus.gnt_id, bus.busy, bus.ack,
                        cmd_addr[w], cmd_write[w], cmd_size[w], w);
            end
            if (drop_early && c == 1) bus.req[w] = 1'b0;
            bus.M_HREADY = (c == 1 + aw);
            bus.M_HRESP  = 1'b0;
         end else if (c <= len - 1) begin
            checks++;
            if (bus.M_HTRANS !== HTRANS_IDLE || bus.ack !== '0 || bus.busy !== 1'b1 ||
                (cmd_write[w] && bus.M_HWDATA !== cmd_wdata[w])) begin
               failures++;
               $display("FAIL data_phase c=%0d: trans=%b hwdata=%h ack=%b busy=%b want trans=00 hwdata=%h ack=0 busy=1",
                        c, bus.M_HTRANS, bus.M_HWDATA, bus.ack, bus.busy, cmd_wdata[w]);
            end
            bus.M_HREADY = (c == len - 1);
            bus.M_HRESP  = eresp && (c >= len - 2);
            bus.M_HRDATA = (c == len - 1) ? hrd : 32'($urandom);
         end else if (c == len) begin
            checks++;
            if (bus.ack !== exp_ack || bus.err !== eresp || bus.rdata !== exp_rd || bus.busy !== 1'b1) begin
               failures++;
               $display("FAIL done_phase c=%0d: ack=%b err=%b rdata=%h busy=%b want ack=%b err=%b rdata=%h busy=1",
                        c, bus.ack, bus.err, bus.rdata, bus.busy, exp_ack, eresp, exp_rd);
            end
            if (!keep) bus.req[w] = 1'b0;
            bus.M_HREADY = 1'b1;
            bus.M_HRESP  = 1'b0;
            last_gnt_m = w;
            rdata_m = exp_rd;
         end else begin
            checks++;
            if (bus.ack !== '0 || bus.busy !== 1'b0 || bus.M_HTRANS !== HTRANS_IDLE) begin
               failures++;
               $display("FAIL idle_after: ack=%b busy=%b trans=%b want ack=0 busy=0 trans=00",
                        bus.ack, bus.busy, bus.M_HTRANS);
            end
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.req = '0;
      bus.M_HREADY = 1'b1;
      bus.M_HRESP = 1'b0;
      bus.M_HRDATA = 32'h0;
      for (int i = 0; i < NREQ; i++) set_cmd(i, 32'h0, 32'h0, 1'b0, HSIZE_WORD);
      last_gnt_m = NREQ - 1;
      rdata_m = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ack !== '0 || bus.err !== 1'b0 || bus.rdata !== 32'h0 || bus.gnt_id !== 2'd0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_req_side: ack=%b err=%b rdata=%h gnt=%0d busy=%b want all zero",
                  bus.ack, bus.err, bus.rdata, bus.gnt_id, bus.busy);
      end
      checks++;
      if (bus.M_HTRANS !== HTRANS_IDLE || bus.M_HADDR !== 32'h0 || bus.M_HWDATA !== 32'h0 ||
          bus.M_HWRITE !== 1'b0 || bus.M_HSIZE !== 3'b010) begin
         failures++;
         $display("FAIL reset_bus_side: trans=%b addr=%h wdata=%h wr=%b size=%b want 00/0/0/0/010",
                  bus.M_HTRANS, bus.M_HADDR, bus.M_HWDATA, bus.M_HWRITE, bus.M_HSIZE);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      int w;
      set_cmd(0, 32'h4000_0010, 32'h0, 1'b0, HSIZE_WORD);
      bus.req[0] = 1'b1;
      xfer(0, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, w);
      checks++;
      if (w != 0 || bus.rdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL single_read: winner=%0d rdata=%h want 0 and 12345678", w, bus.rdata);
      end
   endtask

   task automatic test_write_waits();
      int w;
      set_cmd(1, 32'h4000_0100, 32'hA5A5_A5A5, 1'b1, HSIZE_BYTE);
      bus.req[1] = 1'b1;
      xfer(0, 2, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0, w);
      checks++;
      if (w != 1 || bus.rdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL write_waits: winner=%0d rdata=%h want 1 and 12345678 (held)", w, bus.rdata);
      end
   endtask

   task automatic test_round_robin();
      int w;
      set_cmd(0, 32'h1000_0000, 32'h0, 1'b0, HSIZE_HALF);
      set_cmd(1, 32'h2000_0000, 32'h0, 1'b0, HSIZE_WORD);
      bus.req = 2'b11;
      for (int n = 0; n < 4; n++) begin
         xfer(0, 0, 1'b0, 32'($urandom), 1'b1, 1'b0, w);
         checks++;
         if (w != n % 2) begin
            failures++;
            $display("FAIL round_robin n=%0d: winner=%0d want %0d", n, w, n % 2);
         end
      end
      bus.req = '0;
   endtask

   task automatic test_error();
      int w;
      set_cmd(0, 32'h4000_0044, 32'h0, 1'b0, HSIZE_WORD);
      bus.req[0] = 1'b1;
      xfer(1, 1, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, w);
      checks++;
      if (bus.err !== 1'b1) begin
         failures++;
         $display("FAIL error_hold: err=%b want 1", bus.err);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      set_cmd(1, 32'h4000_0200, 32'h0, 1'b0, HSIZE_WORD);
      bus.req[1] = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.M_HREADY = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.M_HREADY = 1'b0;
      #1 rstn = 1'b0;
      bus.req = '0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.M_HTRANS !== HTRANS_IDLE || bus.gnt_id !== 2'd0 ||
          bus.M_HADDR !== 32'h0 || bus.M_HSIZE !== 3'b010 || bus.rdata !== 32'h0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b ack=%b trans=%b gnt=%0d addr=%h size=%b rdata=%h err=%b want reset values",
                  bus.busy, bus.ack, bus.M_HTRANS, bus.gnt_id, bus.M_HADDR, bus.M_HSIZE, bus.rdata, bus.err);
      end
      bus.M_HREADY = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.ack !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_hold c=%0d: ack=%b busy=%b want 0 0", c, bus.ack, bus.busy);
         end
      end
      rstn = 1'b1;
      last_gnt_m = NREQ - 1;
      rdata_m = 32'h0;
      @(negedge clk);
      set_cmd(0, 32'h4000_0300, 32'h0, 1'b0, HSIZE_WORD);
      bus.req = 2'b11;
      xfer(0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, w);
      checks++;
      if (w != 0) begin
         failures++;
         $display("FAIL reset_first_grant: winner=%0d want 0", w);
      end
      xfer(0, 1, 1'b0, 32'h0000_1111, 1'b0, 1'b0, w);
   endtask

   task automatic test_random();
      int w, aw, dw, lone;
      bit er, drop;
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req[i] && $urandom_range(0, 1) == 1) begin
               set_cmd(i, 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
               bus.req[i] = 1'b1;
            end
         end
         if (bus.req == '0) begin
            lone = $urandom_range(0, NREQ - 1);
            set_cmd(lone, 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
            bus.req[lone] = 1'b1;
         end
         aw = $urandom_range(0, 2);
         dw = $urandom_range(0, 2);
         er = (dw > 0) && ($urandom_range(0, 3) == 0);
         drop = ($urandom_range(0, 3) == 0);
         xfer(aw, dw, er, 32'($urandom), 1'b0, drop, w);
      end
      bus.req = '0;
      @(negedge clk);
   endtask

`ifdef AHB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int ack_cyc;
      ack_cyc = -1;
      set_cmd(0, 32'h4000_0500, 32'h0, 1'b0, HSIZE_WORD);
      bus.req[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.M_HREADY = 1'b1;
      for (int c = 2; c <= 40 && ack_cyc < 0; c++) begin
         @(posedge clk); @(negedge clk);
         bus.M_HREADY = 1'b0;
         if (bus.ack !== '0) ack_cyc = c;
      end
      checks++;
      if (ack_cyc != 10 || bus.err !== 1'b1 || bus.rdata !== 32'hDEAD_BEEF || bus.M_HTRANS !== HTRANS_IDLE) begin
         failures++;
         $display("FAIL timeout: ack_cycle=%0d err=%b rdata=%h trans=%b want 10 1 deadbeef 00",
                  ack_cyc, bus.err, bus.rdata, bus.M_HTRANS);
      end
      bus.req = '0;
      bus.M_HREADY = 1'b1;
      last_gnt_m = 0;
      rdata_m = 32'hDEAD_BEEF;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_write_waits();
      test_round_robin();
      test_error();
      test_reset_mid();
      test_random();
`ifdef AHB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ahb_master_arb.md
# ahb_master_arb

Round-robin arbiter that shares the single AHB-lite master port (M_H*) of the comm controller tile between up to four command requesters: the COMMCTRL backend, the Composer host bridge, and spares. Each requester issues one single-beat read or write at a time over a req/ack command interface. The arbiter sequences exactly one AHB-lite NONSEQ transfer per grant and returns read data and error status. It sits between the requesters and the M_HRDATA/M_HADDR/... pins at the top of the tile.

## Interface
- NREQ, 2, number of requesters (2..4)
- TIMEOUT, 1024, max data-phase wait cycles (used only with the timeout feature)
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request; held high with command stable until ack
- req_addr  in  NREQ x 32  transfer address
- req_wdata  in  NREQ x 32  write data
- req_write  in  NREQ  1 = write
- req_size  in  NREQ x 3  HSIZE (0 byte, 1 half, 2 word)
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rdata  out  32  read data, valid with ack
- err  out  1  error status, valid with ack
- gnt_id  out  2  index of the current or last granted requester
- busy  out  1  high in any state except IDLE
- M_HADDR, M_HWDATA  out  32  AHB address / write data
- M_HWRITE  out  1;  M_HTRANS  out  2;  M_HSIZE  out  3
- M_HRDATA  in  32;  M_HREADY  in  1;  M_HRESP  in  1

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: if any req is set, pick the winner by round-robin, starting at last_gnt+1 mod NREQ. Latch that requester's addr, wdata, write and size into registers. Set gnt_id and go to ADDR.
- ADDR: drive M_HTRANS=NONSEQ (2'b10) with the latched addr, write and size. If M_HREADY=1, go to DATA; otherwise stay in ADDR and hold everything.
- DATA: M_HTRANS=IDLE and M_HWDATA=latched wdata.
  - When M_HREADY=1: capture M_HRDATA into rdata (reads only; rdata holds its previous value on writes), capture err=M_HRESP, then go to DONE.
  - If M_HRESP=1 while M_HREADY=0 (first cycle of a two-cycle error), stay in DATA.
- DONE: pulse ack[gnt_id] for one cycle, update last_gnt=gnt_id, then go to IDLE.
- Requesters must drop req the cycle after ack. If req is still high in IDLE, that is treated as a new request.
- A requester that drops req before ack does not cancel the transfer; ack is still issued.
- A req arriving while busy waits. At most one transfer is outstanding, with no pipelining.
- Reset values: state=IDLE, last_gnt=NREQ-1 (req0 wins the first contest), gnt_id=0, ack=0, err=0, rdata=0, M_HTRANS=IDLE, M_HADDR=0, M_HWDATA=0, M_HWRITE=0, M_HSIZE=3'b010, busy=0.
- If reset is asserted mid-transfer, the FSM returns to IDLE immediately and no ack is issued. Requesters are reset by the same rstn.

## Timing
- Best case (zero wait states): req sampled at edge 0 → ADDR cycle 1 → DATA cycle 2 → ack in cycle 3. That is 3 cycles from req to ack.
- Each cycle M_HREADY is low in ADDR or DATA adds one cycle.
- A back-to-back request from a different requester is granted at the IDLE following DONE. The minimum spacing is 4 cycles per transfer.
- All outputs are registered; there are no combinational paths from req or M_H* inputs to outputs.

## Configuration
- AHB_ARB_TIMEOUT_EN defined:
  - A 16-bit wait counter counts consecutive DATA cycles with M_HREADY=0.
  - When it reaches TIMEOUT, the FSM goes to DONE with err=1 and rdata=32'hDEAD_BEEF.
  - M_HTRANS stays IDLE throughout.
  - The counter clears when the FSM enters DATA.
- Not defined: no counter exists, and DATA waits indefinitely for M_HREADY.

## Structure
- Package ahb_arb_pkg holds:
  - the state enum typedef arb_state_t
  - constants HTRANS_IDLE=2'b00 and HTRANS_NONSEQ=2'b10
  - HSIZE_BYTE/HALF/WORD
  - TIMEOUT_DATA=32'hDEAD_BEEF
- Sub-module rr_pick: combinational round-robin selector. Inputs are req[NREQ] and last_gnt; outputs are winner index and valid. It is instantiated once in the IDLE decision path.

## Test plan
- Single read, req0: addr 0x4000_0010, zero wait states, M_HRDATA=0x1234_5678 → ack[0] 3 cycles after req, rdata=0x1234_5678, err=0.
- Write with 2 wait states in DATA, req1: wdata=0xA5A5_A5A5, size 0 → M_HWDATA stable through the waits, M_HSIZE=0, ack[1] at cycle 5.
- req0 and req1 both asserted continuously, 4 transfers → grants alternate 0,1,0,1 with no starvation.
- Two-cycle error response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) → ack with err=1, state back to IDLE.
- rstn dropped during DATA → outputs immediately return to reset values, no ack pulse, next req0 is granted normally.
- With AHB_ARB_TIMEOUT_EN and TIMEOUT=8, M_HREADY held low → ack with err=1 and rdata=0xDEAD_BEEF, 8 cycles after entering DATA.
